// File: rtl/render_pkg.sv
// render_pkg: screen limits, colour constants and FSM state type shared by the
// sprite renderer and its step timer.
package render_pkg;

   localparam int unsigned X_MAX = 159;
   localparam int unsigned Y_MAX = 119;

   localparam logic [2:0] BLACK = 3'd0;
   localparam logic [2:0] GREEN = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ERASE = 3'd1,
      ST_LATCH = 3'd2,
      ST_DRAW  = 3'd3,
      ST_DONE  = 3'd4
   } render_state_t;

endpackage

// File: rtl/step_timer.sv
// step_timer: frame tick counter feeding a frames-per-step counter; pulses
// o_step for one cycle each time the frame count wraps.
// Ports: clock, resetn (sync, active-low), i_enable (run/freeze), o_step (pulse).
module step_timer #(
   parameter int unsigned FRAME_TICKS     = 833334,
   parameter int unsigned FRAMES_PER_STEP = 15
) (
   input  logic clock,
   input  logic resetn,
   input  logic i_enable,
   output logic o_step
);

   localparam int unsigned TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam int unsigned FRM_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   logic [TICK_W-1:0] r_tick;
   logic [FRM_W-1:0]  r_frame;
   logic              r_step;
   logic              w_tick_wrap;
   logic              w_frame_wrap;

   assign w_tick_wrap  = (r_tick == TICK_W'(FRAME_TICKS - 1));
   assign w_frame_wrap = (r_frame == FRM_W'(FRAMES_PER_STEP - 1));
   assign o_step       = r_step;

   // Counters hold while disabled; step fires on the frame-counter wrap.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_tick  <= '0;
         r_frame <= '0;
         r_step  <= 1'b0;
      end else begin
         r_step <= 1'b0;
         if (i_enable) begin
            if (w_tick_wrap) begin
               r_tick <= '0;
               if (w_frame_wrap) begin
                  r_frame <= '0;
                  r_step  <= 1'b1;
               end else begin
                  r_frame <= r_frame + FRM_W'(1);
               end
            end else begin
               r_tick <= r_tick + TICK_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/sprite_render_engine.sv
// sprite_render_engine: per movement step, erases every sprite at its last drawn
// position, latches new positions, redraws every sprite; one pixel per cycle.
// Ports: clock, resetn (sync, active-low), enable (timing run), spr_x/spr_y/
// spr_colour/spr_valid (packed per-sprite inputs), x/y/colour/plot (pixel out),
// busy, step, pass_done, hit (pulses), overrun (sticky).
module sprite_render_engine #(
   parameter int unsigned NUM_SPRITES     = 2,
   parameter int unsigned SPR_W           = 4,
   parameter int unsigned SPR_H           = 4,
   parameter int unsigned X_W             = 8,
   parameter int unsigned Y_W             = 7,
   parameter int unsigned X_MAX           = render_pkg::X_MAX,
   parameter int unsigned Y_MAX           = render_pkg::Y_MAX,
   parameter int unsigned FRAME_TICKS     = 833334,
   parameter int unsigned FRAMES_PER_STEP = 15,
   parameter logic [2:0]  BG_COLOUR       = render_pkg::BLACK
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic [NUM_SPRITES*X_W-1:0] spr_x,
   input  logic [NUM_SPRITES*Y_W-1:0] spr_y,
   input  logic [NUM_SPRITES*3-1:0]   spr_colour,
   input  logic [NUM_SPRITES-1:0]     spr_valid,
   output logic [X_W-1:0]             x,
   output logic [Y_W-1:0]             y,
   output logic [2:0]                 colour,
   output logic                       plot,
   output logic                       busy,
   output logic                       step,
   output logic                       pass_done,
   output logic                       hit,
   output logic                       overrun
);
   import render_pkg::*;

   localparam int unsigned PIX_PER_SPR = SPR_W * SPR_H;
   localparam int unsigned NUM_PIX     = NUM_SPRITES * PIX_PER_SPR;
   localparam int unsigned IDX_W       = $clog2(NUM_PIX + 1);
   localparam int unsigned S_W         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);

   logic [X_W-1:0] w_spr_x   [NUM_SPRITES];
   logic [Y_W-1:0] w_spr_y   [NUM_SPRITES];
   logic [2:0]     w_spr_col [NUM_SPRITES];

   render_state_t    r_state, w_state_nx;
   logic [IDX_W-1:0] r_idx, w_idx_nx;
   logic [X_W-1:0]   r_shadow_x [NUM_SPRITES];
   logic [Y_W-1:0]   r_shadow_y [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] r_shadow_valid;

   logic [X_W-1:0] r_x, w_x_nx;
   logic [Y_W-1:0] r_y, w_y_nx;
   logic [2:0]     r_colour, w_colour_nx;
   logic           r_plot, w_plot_nx;
   logic           r_busy, r_pass_done, r_hit, w_hit_nx, r_overrun;
   logic           w_step;

   logic [31:0]    w_idx32;
   logic [S_W-1:0] w_s;
   logic [X_W:0]   w_c, w_px;
   logic [Y_W:0]   w_r, w_py;
   logic [X_W-1:0] w_base_x, w_dx;
   logic [Y_W-1:0] w_base_y, w_dy;
   logic           w_base_v, w_live, w_on, w_pix_state;

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_unpack
      assign w_spr_x[g]   = spr_x[g*X_W +: X_W];
      assign w_spr_y[g]   = spr_y[g*Y_W +: Y_W];
      assign w_spr_col[g] = spr_colour[g*3 +: 3];
   end

   step_timer #(
      .FRAME_TICKS     (FRAME_TICKS),
      .FRAMES_PER_STEP (FRAMES_PER_STEP)
   ) u_step_timer (
      .clock    (clock),
      .resetn   (resetn),
      .i_enable (enable),
      .o_step   (w_step)
   );

   // Next state and pixel index; index order is sprite, then row, then column.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      unique case (r_state)
         ST_IDLE: begin
            if (w_step) begin
               w_state_nx = ST_ERASE;
               w_idx_nx   = '0;
            end
         end
         ST_ERASE: begin
            if (r_idx == LAST_IDX) begin
               w_state_nx = ST_LATCH;
               w_idx_nx   = '0;
            end else begin
               w_idx_nx = r_idx + IDX_W'(1);
            end
         end
         ST_LATCH: begin
            w_state_nx = ST_DRAW;
            w_idx_nx   = '0;
         end
         ST_DRAW: begin
            if (r_idx == LAST_IDX) begin
               w_state_nx = ST_DONE;
            end else begin
               w_idx_nx = r_idx + IDX_W'(1);
            end
         end
         ST_DONE:  w_state_nx = ST_IDLE;
         default:  w_state_nx = ST_IDLE;
      endcase
   end

   // Pixel for the upcoming cycle, so the registered outputs line up with the
   // state register. The first DRAW pixel is formed while the shadow is still
   // being written, so it reads the live inputs being latched.
   always_comb begin
      w_idx32  = 32'(w_idx_nx);
      w_s      = S_W'(w_idx32 / PIX_PER_SPR);
      w_r      = (Y_W+1)'((w_idx32 / SPR_W) % SPR_H);
      w_c      = (X_W+1)'(w_idx32 % SPR_W);
      w_live   = (r_state == ST_LATCH);
      w_base_x = w_live ? w_spr_x[w_s] : r_shadow_x[w_s];
      w_base_y = w_live ? w_spr_y[w_s] : r_shadow_y[w_s];
      w_base_v = w_live ? spr_valid[w_s] : r_shadow_valid[w_s];
      w_px     = {1'b0, w_base_x} + w_c;
      w_py     = {1'b0, w_base_y} + w_r;
      w_on     = (32'(w_px) <= X_MAX) && (32'(w_py) <= Y_MAX);
      w_pix_state = (w_state_nx == ST_ERASE) || (w_state_nx == ST_DRAW);

      w_plot_nx   = w_pix_state && w_base_v && w_on;
      w_x_nx      = '0;
      w_y_nx      = '0;
      w_colour_nx = '0;
      if (w_pix_state) begin
         // Saturate instead of truncating so off-screen pixels never alias on-screen.
         w_x_nx      = w_px[X_W] ? {X_W{1'b1}} : w_px[X_W-1:0];
         w_y_nx      = w_py[Y_W] ? {Y_W{1'b1}} : w_py[Y_W-1:0];
         w_colour_nx = (w_state_nx == ST_DRAW) ? w_spr_col[w_s] : BG_COLOUR;
      end
   end

   // Player-vs-obstacle overlap on the positions being latched; touching edges do not count.
   always_comb begin
      w_hit_nx = 1'b0;
      w_dx     = '0;
      w_dy     = '0;
      for (int unsigned i = 1; i < NUM_SPRITES; i++) begin
         w_dx = (w_spr_x[0] >= w_spr_x[i]) ? (w_spr_x[0] - w_spr_x[i]) : (w_spr_x[i] - w_spr_x[0]);
         w_dy = (w_spr_y[0] >= w_spr_y[i]) ? (w_spr_y[0] - w_spr_y[i]) : (w_spr_y[i] - w_spr_y[0]);
         if (spr_valid[i] && (32'(w_dx) < SPR_W) && (32'(w_dy) < SPR_H)) begin
            w_hit_nx = 1'b1;
         end
      end
      w_hit_nx = w_hit_nx && spr_valid[0] && (r_state == ST_LATCH);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state        <= ST_IDLE;
         r_idx          <= '0;
         r_shadow_valid <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_shadow_x[i] <= '0;
            r_shadow_y[i] <= '0;
         end
         r_x         <= '0;
         r_y         <= '0;
         r_colour    <= '0;
         r_plot      <= 1'b0;
         r_busy      <= 1'b0;
         r_pass_done <= 1'b0;
         r_hit       <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         if (r_state == ST_LATCH) begin
            r_shadow_valid <= spr_valid;
            for (int i = 0; i < NUM_SPRITES; i++) begin
               r_shadow_x[i] <= w_spr_x[i];
               r_shadow_y[i] <= w_spr_y[i];
            end
         end
         r_x         <= w_x_nx;
         r_y         <= w_y_nx;
         r_colour    <= w_colour_nx;
         r_plot      <= w_plot_nx;
         r_busy      <= (w_state_nx != ST_IDLE);
         r_pass_done <= (w_state_nx == ST_DONE);
         r_hit       <= w_hit_nx;
         if (w_step && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign x         = r_x;
   assign y         = r_y;
   assign colour    = r_colour;
   assign plot      = r_plot;
   assign busy      = r_busy;
   assign step      = w_step;
   assign pass_done = r_pass_done;
   assign hit       = r_hit;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_sprite_render_engine.sv
// tb_sprite_render_engine: table of redraw passes checked pixel by pixel against
// a small pass model, plus hand sequences for overrun and mid-pass reset.
module tb_sprite_render_engine;

   localparam int N     = 2;
   localparam int SW    = 4;
   localparam int SH    = 4;
   localparam int NPIX  = N * SW * SH;
   localparam int PASS  = 2 * NPIX + 2;

   logic         clock;
   logic         resetn;
   logic         enable;
   logic [15:0]  spr_x;
   logic [13:0]  spr_y;
   logic [5:0]   spr_colour;
   logic [1:0]   spr_valid;

   logic [7:0] x;      logic [6:0] y;      logic [2:0] colour;
   logic plot, busy, step, pass_done, hit, overrun;
   logic [7:0] o_x;    logic [6:0] o_y;    logic [2:0] o_colour;
   logic o_plot, o_busy, o_step, o_pass_done, o_hit, o_overrun;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: previously latched (shadow) and newly applied sprites.
   int m_px [N]; int m_py [N]; bit m_pv [N];
   int m_nx [N]; int m_ny [N]; bit m_nv [N];
   int m_col [N];

   typedef struct {
      int x0; int y0; bit v0;
      int x1; int y1; bit v1;
      bit exp_hit;
      int exp_cnt;
   } pass_vec_t;

   pass_vec_t tab [8];

   sprite_render_engine #(
      .NUM_SPRITES(N), .SPR_W(SW), .SPR_H(SH), .X_W(8), .Y_W(7),
      .X_MAX(159), .Y_MAX(119), .FRAME_TICKS(4), .FRAMES_PER_STEP(2), .BG_COLOUR(3'd0)
   ) dut (
      .clock(clock), .resetn(resetn), .enable(enable),
      .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour), .spr_valid(spr_valid),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .step(step),
      .pass_done(pass_done), .hit(hit), .overrun(overrun)
   );

   sprite_render_engine #(
      .NUM_SPRITES(N), .SPR_W(SW), .SPR_H(SH), .X_W(8), .Y_W(7),
      .X_MAX(159), .Y_MAX(119), .FRAME_TICKS(4), .FRAMES_PER_STEP(1), .BG_COLOUR(3'd0)
   ) dut_ovr (
      .clock(clock), .resetn(resetn), .enable(enable),
      .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour), .spr_valid(spr_valid),
      .x(o_x), .y(o_y), .colour(o_colour), .plot(o_plot), .busy(o_busy), .step(o_step),
      .pass_done(o_pass_done), .hit(o_hit), .overrun(o_overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic set_sprites(input int x0, input int y0, input bit v0,
                              input int x1, input int y1, input bit v1);
      m_nx[0] = x0; m_ny[0] = y0; m_nv[0] = v0;
      m_nx[1] = x1; m_ny[1] = y1; m_nv[1] = v1;
      spr_x     = {8'(x1), 8'(x0)};
      spr_y     = {7'(y1), 7'(y0)};
      spr_valid = {v1, v0};
   endtask

   // Waits for a step that arrives while the engine is idle (start of a pass).
   task automatic wait_idle_step(input string tag);
      bit found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clock);
         if (step && !busy) found = 1'b1;
      end
      chk({tag, " step_wait"}, 32'(found), 32'd1);
   endtask

   // Checks the 66 pass cycles after the starting step, plus the cycle after.
   task automatic run_pass(input string tag, input bit exp_hit, input int exp_cnt);
      int cnt, idx, s, r, c, px, py;
      bit ev, onscr;
      logic [2:0] ecol;
      cnt = 0;
      for (int k = 1; k <= PASS + 1; k++) begin
         @(negedge clock);
         ev = 1'b0; px = 0; py = 0; ecol = 3'd0;
         if (k <= NPIX) begin
            idx = k - 1; s = idx / (SW*SH); r = (idx / SW) % SH; c = idx % SW;
            px = m_px[s] + c; py = m_py[s] + r; ev = m_pv[s];
         end else if (k >= NPIX + 2 && k <= 2*NPIX + 1) begin
            idx = k - NPIX - 2; s = idx / (SW*SH); r = (idx / SW) % SH; c = idx % SW;
            px = m_nx[s] + c; py = m_ny[s] + r; ev = m_nv[s]; ecol = 3'(m_col[s]);
         end
         onscr = ev && (px <= 159) && (py <= 119);
         chk($sformatf("%s k%0d plot", tag, k), 32'(plot), 32'(onscr));
         if (plot) cnt++;
         if (onscr) begin
            chk($sformatf("%s k%0d x", tag, k), 32'(x), 32'(px));
            chk($sformatf("%s k%0d y", tag, k), 32'(y), 32'(py));
            chk($sformatf("%s k%0d colour", tag, k), 32'(colour), 32'(ecol));
         end else if (ev && px > 159) begin
            chk($sformatf("%s k%0d x_offscreen", tag, k), 32'(x > 8'd159), 32'd1);
         end else if (ev && py > 119) begin
            chk($sformatf("%s k%0d y_offscreen", tag, k), 32'(y > 7'd119), 32'd1);
         end
         chk($sformatf("%s k%0d busy", tag, k), 32'(busy), 32'(k <= PASS));
         chk($sformatf("%s k%0d pass_done", tag, k), 32'(pass_done), 32'(k == PASS));
         chk($sformatf("%s k%0d hit", tag, k), 32'(hit), 32'((k == NPIX + 2) ? exp_hit : 1'b0));
      end
      chk({tag, " plot_count"}, 32'(cnt), 32'(exp_cnt));
      for (int i = 0; i < N; i++) begin
         m_px[i] = m_nx[i]; m_py[i] = m_ny[i]; m_pv[i] = m_nv[i];
      end
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      int main_k, ovr_k, blen, pd_k;
      bit running;

      //          x0  y0 v0   x1   y1 v1 hit cnt
      tab[0] = '{ 10, 58, 1,   0,   0, 0, 0, 16};
      tab[1] = '{ 11, 58, 1,   0,   0, 0, 0, 32};
      tab[2] = '{ 11, 58, 1, 158, 118, 1, 0, 36};
      tab[3] = '{ 20, 50, 1,  23,  53, 1, 1, 52};
      tab[4] = '{ 20, 50, 1,  24,  50, 1, 0, 64};
      tab[5] = '{ 20, 50, 1,  17,  47, 1, 1, 64};
      tab[6] = '{ 20, 50, 0,  20,  50, 1, 0, 48};
      tab[7] = '{  5,  5, 0, 254, 126, 1, 0, 16};

      m_col[0] = int'(render_pkg::GREEN);
      m_col[1] = 5;
      spr_colour = {3'd5, render_pkg::GREEN};
      for (int i = 0; i < N; i++) begin
         m_px[i] = 0; m_py[i] = 0; m_pv[i] = 1'b0;
      end

      resetn = 1'b0;
      enable = 1'b1;
      set_sprites(tab[0].x0, tab[0].y0, tab[0].v0, tab[0].x1, tab[0].y1, tab[0].v1);
      repeat (3) @(negedge clock);
      chk("reset x", 32'(x), 0);
      chk("reset y", 32'(y), 0);
      chk("reset colour", 32'(colour), 0);
      chk("reset plot", 32'(plot), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset step", 32'(step), 0);
      chk("reset pass_done", 32'(pass_done), 0);
      chk("reset hit", 32'(hit), 0);
      chk("reset overrun", 32'(overrun), 0);
      resetn = 1'b1;

      // First step: every 8 cycles for the main engine, every 4 for the fast one.
      main_k = 0; ovr_k = 0;
      for (int k = 1; k <= 20 && main_k == 0; k++) begin
         @(negedge clock);
         if (o_step && ovr_k == 0) ovr_k = k;
         if (step) main_k = k;
      end
      chk("first_step_cycle", 32'(main_k), 32'd8);
      chk("fast_first_step_cycle", 32'(ovr_k), 32'd4);
      chk("first_step_busy", 32'(busy), 32'd0);
      run_pass("p0", tab[0].exp_hit, tab[0].exp_cnt);

      for (int sc = 1; sc < 8; sc++) begin
         set_sprites(tab[sc].x0, tab[sc].y0, tab[sc].v0, tab[sc].x1, tab[sc].y1, tab[sc].v1);
         wait_idle_step($sformatf("p%0d", sc));
         run_pass($sformatf("p%0d", sc), tab[sc].exp_hit, tab[sc].exp_cnt);
      end

      // Steps kept arriving during every 66-cycle pass.
      chk("main overrun", 32'(overrun), 32'd1);
      chk("fast overrun", 32'(o_overrun), 32'd1);

      // Fast-stepping engine still completes whole passes.
      running = 1'b0;
      for (int n = 0; n < 200 && !running; n++) begin
         @(negedge clock);
         if (o_step && !o_busy) running = 1'b1;
      end
      chk("fast step_wait", 32'(running), 32'd1);
      blen = 0; pd_k = 0;
      for (int n = 1; n <= 100 && running; n++) begin
         @(negedge clock);
         if (o_pass_done) pd_k = n;
         if (o_busy) blen++;
         else running = 1'b0;
      end
      chk("fast busy_length", 32'(blen), 32'(PASS));
      chk("fast pass_done_cycle", 32'(pd_k), 32'(PASS));
      chk("fast overrun sticky", 32'(o_overrun), 32'd1);

      // Reset in the middle of DRAW abandons the pass.
      set_sprites(10, 58, 1, 30, 30, 1);
      wait_idle_step("rst");
      repeat (40) @(negedge clock);
      chk("pre_reset busy", 32'(busy), 32'd1);
      resetn = 1'b0;
      @(negedge clock);
      chk("mid_reset plot", 32'(plot), 32'd0);
      chk("mid_reset busy", 32'(busy), 32'd0);
      chk("mid_reset overrun", 32'(overrun), 32'd0);
      resetn = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clock);
         chk($sformatf("post_reset c%0d plot", n), 32'(plot), 32'd0);
      end
      for (int i = 0; i < N; i++) m_pv[i] = 1'b0;
      wait_idle_step("after_rst");
      run_pass("after_rst", 1'b0, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_render_engine.md
Name: sprite_render_engine

Overview:
- Multi-sprite successor to the single-object draw datapath for the 160x120, 3-bit-colour VGA path.
- On each movement step it performs one redraw pass: it erases every sprite at its previously drawn position, latches the new positions, then redraws every sprite.
- Emits one pixel per cycle to the VGA adapter.
- Adds internal frame/step timing, screen-edge clipping, overrun detection and sprite-0 collision detection.

Parameters:
- NUM_SPRITES, 2, number of sprites; sprite 0 is the player, 1..N-1 are obstacles
- SPR_W, 4, sprite width in pixels (power of 2, 1..16)
- SPR_H, 4, sprite height in pixels (power of 2, 1..16)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- X_MAX, 159, last visible column
- Y_MAX, 119, last visible row
- FRAME_TICKS, 833334, clock cycles per frame (60 Hz at 50 MHz)
- FRAMES_PER_STEP, 15, frames per movement step
- BG_COLOUR, 3'd0, erase colour

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- enable  in  1  run timing counters; low freezes the frame and step counters
- spr_x  in  NUM_SPRITES*X_W  packed sprite x positions (top-left corner); sprite i occupies slice i
- spr_y  in  NUM_SPRITES*Y_W  packed sprite y positions (top-left corner)
- spr_colour  in  NUM_SPRITES*3  packed sprite colours
- spr_valid  in  NUM_SPRITES  sprite i is drawn when set
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel write enable
- busy  out  1  redraw pass in progress
- step  out  1  one-cycle pulse at each movement step; game logic updates positions on it
- pass_done  out  1  one-cycle pulse when the last pixel of a pass has been issued
- hit  out  1  one-cycle pulse: sprite 0 overlaps a valid obstacle
- overrun  out  1  sticky: a step arrived while busy; cleared only by reset

Behaviour:
- Reset (clock edge with resetn=0): all outputs 0, FSM IDLE, counters 0, all shadow-valid bits 0. Reset takes priority over everything, including a pass in progress; a pass interrupted by reset is abandoned, no further pixels are issued, and the next pass erases nothing.
- Frame counter: counts 0..FRAME_TICKS-1 while enable=1, holding otherwise. At wrap, the frame counter increments 0..FRAMES_PER_STEP-1. At frame-counter wrap, step=1 for one cycle.
- FSM states: IDLE, ERASE, LATCH, DRAW, DONE.
  - IDLE: on step, go to ERASE, busy=1.
  - ERASE: iterate sprite index s = 0..N-1, then row r, then col c, one pixel per cycle. colour=BG_COLOUR at shadow position. plot=1 only if shadow_valid[s] and the pixel is on screen.
  - LATCH: 1 cycle. shadow_x/y/valid <= spr_x/spr_y/spr_valid. Collision compare is evaluated here.
  - DRAW: same iteration as ERASE using the shadow positions and each sprite's colour.
  - DONE: 1 cycle. pass_done=1, busy falls next cycle, return to IDLE.
- Latency: step is at cycle T. The first ERASE pixel is at T+1. A full pass is 2*N*SPR_W*SPR_H + 2 cycles after T; busy is high for that long.
- Iteration runs for invalid sprites too, with plot=0, so pass length is constant.
- x, y, colour and plot are registered and change together.
- Clipping: pixel coordinates are computed at X_W+1 / Y_W+1 bits. plot=0 if x>X_MAX or y>Y_MAX; the counter still advances and coordinates never wrap onto the screen.
- Colour during DRAW uses colour slice s, sampled from spr_colour live.
- Collision: hit=1 in the cycle after LATCH if shadow_valid[0] and, for any valid i≥1, |x0-xi|<SPR_W and |y0-yi|<SPR_H. Edge-touching boxes (distance = SPR_W) are not a hit.
- step while busy: the pass is not restarted, the step is dropped and overrun<=1. The step output still pulses.
- enable=0 mid-pass: the pass completes; only the timing counters freeze.
- N=1: no collision is possible and hit stays 0.

Decomposition:
- Shared package render_pkg holds:
  - screen constants X_MAX, Y_MAX
  - colour constants BLACK=0, GREEN=2
  - FSM state enum render_state_t
- Sub-module step_timer (frame and step counters; outputs step) is natural, generalising the existing delay/frame counter pair.
- Pixel iteration and collision stay in the top module.

Test Plan:
- Bench parameters: FRAME_TICKS=4, FRAMES_PER_STEP=2, N=2, 4x4 sprites.
- Reset, enable=1 -> step pulses every 8 cycles. The first pass has 32 ERASE cycles with plot=0, then 16 GREEN pixels at (10..13, 58..61). pass_done at T+66.
- Move sprite 0 from (10,58) to (11,58) at step -> second pass erases (10..13, 58..61) with colour 0, then draws (11..14, 58..61).
- Sprite 1 at (158,118), valid -> only (158..159, 118..119) plotted. Other pixels give plot=0 and x never reads as 0..3.
- Sprite 0 at (20,50), sprite 1 at (23,53) -> hit pulse. Sprite 1 at (24,50) -> no hit.
- FRAMES_PER_STEP=1, FRAME_TICKS=4 (step faster than a pass) -> overrun=1, and the pass in progress completes with all 66 cycles.
- Reset asserted mid-DRAW -> plot=0 and busy=0 next cycle. The next pass issues no erase pixels.
